// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU control codes, ALUOp classes,
// funct7 patterns and the issue FSM state.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SLL  = 3'b011,
        ALU_MUL  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SRAI = 3'b111
    } alu_ctl_e;

    typedef enum logic [1:0] {
        ALUOP_LS  = 2'b00,
        ALUOP_BR  = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_IMM = 2'b11
    } alu_op_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } issue_state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUOp/funct7/funct3 decode to the 3-bit ALU control code.
// Unsupported encodings raise illegal_o and fall back to add.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [6:0] funct7_i,
    input  logic [2:0] funct3_i,
    output logic [2:0] alu_ctl_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctl_o = ALU_ADD;
        illegal_o = 1'b0;
        case (alu_op_e'(alu_op_i))
            ALUOP_LS: alu_ctl_o = ALU_ADD;
            ALUOP_BR: alu_ctl_o = ALU_SUB;
            ALUOP_R: begin
                case ({funct7_i, funct3_i})
                    {F7_BASE,   3'b111}: alu_ctl_o = ALU_AND;
                    {F7_BASE,   3'b100}: alu_ctl_o = ALU_XOR;
                    {F7_BASE,   3'b001}: alu_ctl_o = ALU_SLL;
                    {F7_BASE,   3'b000}: alu_ctl_o = ALU_ADD;
                    {F7_ALT,    3'b000}: alu_ctl_o = ALU_SUB;
                    {F7_MULDIV, 3'b000}: alu_ctl_o = ALU_MUL;
                    default:             illegal_o = 1'b1;
                endcase
            end
            ALUOP_IMM: begin
                // addi ignores funct7; srai needs the alternate funct7 pattern
                if (funct3_i == 3'b000) begin
                    alu_ctl_o = ALU_ADD;
                end else if (funct3_i == 3'b101 && funct7_i == F7_ALT) begin
                    alu_ctl_o = ALU_SRAI;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU: decode, operand-B select, stall/flush,
// and multi-cycle MUL hold. Optional trap on illegal encodings: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [6:0]        funct7_i,
    input  logic [2:0]        funct3_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [2:0]        ALUCtl_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              RegWrite_o,
    output logic [4:0]        rd_addr_o,
    output logic              illegal_o
);

    localparam logic [3:0] HOLD_INIT = 4'(MUL_LATENCY - 1);

    issue_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [2:0]        ctl_q, ctl_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              rw_q, rw_d;
    logic [4:0]        rd_q, rd_d;
    logic              ill_q, ill_d;

    logic [2:0] dec_ctl;
    logic       dec_illegal;
    logic       trap;

    alu_ctl_decode u_dec (
        .alu_op_i  (ALUOp_i),
        .funct7_i  (funct7_i),
        .funct3_i  (funct3_i),
        .alu_ctl_o (dec_ctl),
        .illegal_o (dec_illegal)
    );

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign trap = valid_i && dec_illegal;
`else
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ctl_d   = ctl_q;
        a_d     = a_q;
        b_d     = b_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        ill_d   = ill_q;
        case (state_q)
            ST_IDLE: begin
                if (!stall_i) begin
                    if (flush_i || trap) begin
                        valid_d = 1'b0;
                        ctl_d   = 3'b000;
                        a_d     = '0;
                        b_d     = '0;
                        rw_d    = 1'b0;
                        rd_d    = '0;
                        ill_d   = ill_q | (trap & ~flush_i);
                    end else begin
                        valid_d = valid_i;
                        ctl_d   = dec_ctl;
                        a_d     = rs1_data_i;
                        b_d     = ALUSrc_i ? imm_i : rs2_data_i;
                        rw_d    = RegWrite_i && valid_i;
                        rd_d    = rd_addr_i;
                        if (MUL_LATENCY > 1 && valid_i && dec_ctl == ALU_MUL) begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_INIT;
                        end
                    end
                end
            end
            ST_HOLD: begin
                // flush is ignored here: the held MUL is older than the branch
                if (!stall_i) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            ctl_q   <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            ill_q   <= ill_d;
        end
    end

    assign ready_o    = (state_q == ST_IDLE);
    assign valid_o    = valid_q;
    assign ALUCtl_o   = ctl_q;
    assign a_o        = a_q;
    assign b_o        = b_q;
    assign RegWrite_o = rw_q;
    assign rd_addr_o  = rd_q;
    assign illegal_o  = ill_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU control/operand interface.
- Decodes ALUOp plus funct7/funct3 into the 3-bit ALU control code and selects operand B (register or immediate).
- Registers control, operands and writeback info into the ID/EX boundary feeding the ALU.
- Handles pipeline stall and flush, and holds a MUL in EX for a configurable number of cycles, back-pressuring decode meanwhile.

Parameters:
- DATA_W, 32, operand width.
- MUL_LATENCY, 1, cycles a MUL occupies EX (1 = single cycle, no hold); legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  decode stage presents an instruction.
- stall_i  input  1  downstream hazard stall; hold all outputs.
- flush_i  input  1  kill the instruction entering EX (branch taken).
- ALUOp_i  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct7_i  input  7  instruction funct7.
- funct3_i  input  3  instruction funct3.
- ALUSrc_i  input  1  1 = operand B from imm_i.
- RegWrite_i  input  1  writeback enable.
- rd_addr_i  input  5  destination register.
- rs1_data_i  input  DATA_W  operand A source.
- rs2_data_i  input  DATA_W  register operand B source.
- imm_i  input  DATA_W  sign-extended immediate.
- ready_o  output  1  stage can accept; low during a MUL hold.
- valid_o  output  1  EX holds a live instruction.
- ALUCtl_o  output  3  ALU control code.
- a_o  output  DATA_W  operand A.
- b_o  output  DATA_W  operand B.
- RegWrite_o  output  1  gated writeback enable.
- rd_addr_o  output  5  destination register.
- illegal_o  output  1  sticky unsupported-encoding flag (optional feature).

Behaviour:
- Reset: all outputs 0 except ready_o = 1; FSM to IDLE; hold counter 0. Reset mid-hold abandons the MUL.
- Decode, combinational, for the registered input:
  - ALUOp 00 -> add 010.
  - ALUOp 01 -> sub 110.
  - ALUOp 10, funct7/funct3:
    - 0000000/111 -> and 000
    - 0000000/100 -> xor 001
    - 0000000/001 -> sll 011
    - 0000000/000 -> add 010
    - 0100000/000 -> sub 110
    - 0000001/000 -> mul 101
  - ALUOp 11: funct3 000 -> add 010; funct3 101 with funct7 0100000 -> srai 111.
  - Anything else is illegal and decodes as add 010.
- Operand B = ALUSrc_i ? imm_i : rs2_data_i. a_o = rs1_data_i. No arithmetic in this block.
- Latency: 1 cycle, input sampled at the edge and visible on outputs after it.
- Load condition: ready_o && !stall_i.
  - flush_i wins: loads a bubble (valid_o = 0, RegWrite_o = 0, ALUCtl_o = 000, operands 0).
  - Otherwise loads valid_i and the decoded fields; RegWrite_o = RegWrite_i && valid_i.
- stall_i high: all registers hold. flush_i during stall is ignored; upstream re-asserts it.
- FSM:
  - IDLE: on loading a valid MUL with MUL_LATENCY > 1, go to HOLD with counter = MUL_LATENCY-1 and ready_o = 0.
  - HOLD: outputs frozen; counter decrements each cycle stall_i is low; at counter = 1 with no stall, return to IDLE and raise ready_o for the next cycle.
  - flush_i in HOLD is ignored, because the MUL is older than the branch.
  - MUL_LATENCY = 1 never enters HOLD.
- Back-to-back MULs: each one receives a full hold.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal encoding loads as a bubble (valid_o = 0, RegWrite_o = 0).
  - illegal_o is set and stays set until reset.
- Undefined:
  - An illegal encoding issues as add with its original RegWrite.
  - illegal_o is tied 0.

Decomposition:
- Package alu_pkg holds:
  - ALUCtl codes: ALU_AND, ALU_XOR, ALU_ADD, ALU_SLL, ALU_MUL, ALU_SUB, ALU_SRAI.
  - ALUOp codes.
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV.
  - FSM state encoding.
- One combinational sub-module, alu_ctl_decode (ALUOp, funct7, funct3 -> ALUCtl, illegal). The stage instantiates it.

Test Plan:
- R-type xor (ALUOp 10, funct7 0000000, funct3 100, rs1 = 0xF0F0_0000, rs2 = 0x0FF0_0000) -> next cycle: ALUCtl_o 001, a_o 0xF0F0_0000, b_o 0x0FF0_0000, valid_o 1.
- srai (ALUOp 11, funct3 101, funct7 0100000, ALUSrc 1, imm 3) -> ALUCtl_o 111, b_o 3. Same with funct7 0000000 -> illegal: bubble plus illegal_o = 1 when the macro is defined; add with illegal_o = 0 when not.
- MUL_LATENCY = 4, mul issued -> ready_o low exactly 3 cycles, outputs frozen, then the next add loads. stall_i asserted for 2 cycles mid-hold -> ready_o low exactly 5 cycles.
- stall_i high 2 cycles while inputs change -> outputs unchanged. flush_i with valid add -> valid_o 0, RegWrite_o 0, ALUCtl_o 000.
- flush_i during a MUL hold -> ignored, MUL outputs persist. rst_i pulsed low mid-hold -> all outputs 0 and ready_o 1 immediately, without waiting for a clock.
- beq (ALUOp 01) with RegWrite_i 0 -> ALUCtl_o 110, RegWrite_o 0. sw (ALUOp 00, ALUSrc 1, imm 0xFFFF_FFFC) -> ALUCtl_o 010, b_o 0xFFFF_FFFC.
